// File: rtl/iob_cache_read_channel_axi_if.sv
// AXI4 read-address (AR) and read-data (R) channel bundle used by the cache
// line-fill engine.
//   master modport : the line-fill engine (drives AR, drives rready)
//   slave  modport : the interconnect / memory side
// AR signals: arvalid, arready, araddr, arlen, arsize, arburst, arid,
//             arlock, arcache, arprot, arqos
// R  signals: rvalid, rready, rdata, rresp, rlast, rid
interface iob_cache_read_channel_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/iob_cache_read_channel_axi.sv
// Line-fill read engine for the cache AXI back-end. On a replacement request
// it issues one INCR burst covering a full cache line and streams every
// accepted beat, tagged with its beat index, into the cache data memory.
// Ports:
//   clk_i, cke_i, arst_n_i      clock, clock enable (0 freezes state), async active-low reset
//   replace_valid_i/addr_i      line-fill request and line address (sampled in IDLE)
//   replace_o                   busy while a fill is in progress
//   read_valid_o/addr_o/rdata_o beat write into the data memory
//   error_o                     one-cycle pulse at fill end when the burst was faulty
//   axi                         AXI AR/R channels (master side)
module iob_cache_read_channel_axi #(
  parameter int BE_ADDR_W     = 32,
  parameter int BE_DATA_W     = 32,
  parameter int DATA_W        = 32,
  parameter int WORD_OFFSET_W = 2,
  parameter int AXI_ID_W      = 1,
  parameter int AXI_ID        = 0,
  parameter int AXI_LEN_W     = 8,
  localparam int OFF_W  = $clog2(BE_DATA_W / 8),
  localparam int BEAT_W = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W),
  localparam int BEATS  = 1 << BEAT_W,
  localparam int LINE_W = BE_ADDR_W - OFF_W - BEAT_W,
  localparam int CNT_W  = (BEAT_W > 0) ? BEAT_W : 1
) (
  input  logic                 clk_i,
  input  logic                 cke_i,
  input  logic                 arst_n_i,
  input  logic                 replace_valid_i,
  input  logic [LINE_W-1:0]    replace_addr_i,
  output logic                 replace_o,
  output logic                 read_valid_o,
  output logic [CNT_W-1:0]     read_addr_o,
  output logic [BE_DATA_W-1:0] read_rdata_o,
  output logic                 error_o,
  iob_cache_read_channel_axi_if.master axi
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, END} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_addr_q, line_addr_d;
  logic              err_q, err_d;
  logic              replace_q;
  logic              beat;
  logic              last_beat;

  // Fixed AR attributes: full-line INCR burst, modifiable/bufferable cache hint.
  assign axi.araddr  = {line_addr_q, {(BE_ADDR_W - LINE_W){1'b0}}};
  assign axi.arlen   = AXI_LEN_W'(BEATS - 1);
  assign axi.arsize  = 3'(OFF_W);
  assign axi.arburst = 2'b01;
  assign axi.arid    = AXI_ID_W'(AXI_ID);
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0011;
  assign axi.arprot  = 3'b000;
  assign axi.arqos   = 4'b0000;

  // rready is withheld while the clock enable is low so that no beat can be
  // consumed by the interconnect while the counter is frozen.
  assign axi.arvalid  = (state_q == ADDR);
  assign axi.rready   = (state_q == DATA) & cke_i;
  assign beat         = axi.rvalid & axi.rready;
  assign last_beat    = (cnt_q == CNT_W'(BEATS - 1));

  assign replace_o    = replace_q;
  assign read_valid_o = beat;
  assign read_addr_o  = cnt_q;
  assign read_rdata_o = axi.rdata;
  assign error_o      = (state_q == END) & err_q;

  // Next-state logic. The fill ends on whichever comes first: rlast or the
  // final beat index, so a short burst never stalls the engine and a missing
  // rlast never overruns the line. Either disagreement is flagged as an error.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (replace_valid_i) begin
          line_addr_d = replace_addr_i;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (axi.arready) state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          err_d = err_q | (axi.rresp != 2'b00) | (axi.rid != AXI_ID_W'(AXI_ID))
                  | (axi.rlast ^ last_beat);
          if (axi.rlast | last_beat) state_d = END;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; busy flag is registered from the next state so it rises
  // the cycle after the request and falls the cycle after END.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_addr_q <= '0;
      err_q       <= 1'b0;
      replace_q   <= 1'b0;
    end else if (cke_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_addr_q <= line_addr_d;
      err_q       <= err_d;
      replace_q   <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_iob_cache_read_channel_axi.sv
// Self-checking bench for the cache line-fill read engine (32/32, 4-beat line).
// A cycle table of inputs and expected outputs covers the basic fill, a
// faulty rresp, an early rlast and back-to-back fills; hand-written sequences
// cover a stalled AR, rvalid gaps, a mid-burst reset and clock-enable freezes.
module tb_iob_cache_read_channel_axi;

  typedef struct {
    logic        cke;
    logic        rv;
    logic [27:0] ra;
    logic        ard;
    logic        rvl;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rl;
    logic        eRep;
    logic        eArv;
    logic [31:0] eAra;
    logic        eRdy;
    logic        eRv;
    logic [1:0]  eRadr;
    logic        eErr;
  } vec_t;

  logic        clk;
  logic        cke;
  logic        arst_n;
  logic        replace_valid;
  logic [27:0] replace_addr;
  logic        replace;
  logic        read_valid;
  logic [1:0]  read_addr;
  logic [31:0] read_rdata;
  logic        error;

  int checks   = 0;
  int failures = 0;
  vec_t table_q[$];

  iob_cache_read_channel_axi_if #(.ADDR_W(32), .DATA_W(32), .ID_W(1), .LEN_W(8)) axi_bus ();

  iob_cache_read_channel_axi dut (
    .clk_i           (clk),
    .cke_i           (cke),
    .arst_n_i        (arst_n),
    .replace_valid_i (replace_valid),
    .replace_addr_i  (replace_addr),
    .replace_o       (replace),
    .read_valid_o    (read_valid),
    .read_addr_o     (read_addr),
    .read_rdata_o    (read_rdata),
    .error_o         (error),
    .axi             (axi_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic cke_v, input logic rv, input logic [27:0] ra,
                              input logic ard, input logic rvl, input logic [31:0] rd,
                              input logic [1:0] rr, input logic rl, input logic eRep,
                              input logic eArv, input logic [31:0] eAra, input logic eRdy,
                              input logic eRv, input logic [1:0] eRadr, input logic eErr);
    vec_t v;
    v.cke = cke_v; v.rv = rv; v.ra = ra; v.ard = ard; v.rvl = rvl; v.rd = rd; v.rr = rr;
    v.rl = rl; v.eRep = eRep; v.eArv = eArv; v.eAra = eAra; v.eRdy = eRdy; v.eRv = eRv;
    v.eRadr = eRadr; v.eErr = eErr;
    return v;
  endfunction

  // IDLE cycle, optionally carrying a request.
  function automatic vec_t vIdle(input logic rv, input logic [27:0] ra, input logic [31:0] eAra);
    return mk(1'b1, rv, ra, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, eAra, 1'b0, 1'b0, 2'd0, 1'b0);
  endfunction

  // ADDR cycle with the given arready.
  function automatic vec_t vAddr(input logic ard, input logic [31:0] eAra);
    return mk(1'b1, 1'b0, 28'h0, ard, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, eAra, 1'b0, 1'b0, 2'd0, 1'b0);
  endfunction

  // DATA cycle; with cke low nothing may be accepted.
  function automatic vec_t vBeat(input logic cke_v, input logic rvl, input logic [31:0] rd,
                                 input logic [1:0] rr, input logic rl, input logic [1:0] eRadr,
                                 input logic [31:0] eAra);
    return mk(cke_v, 1'b0, 28'h0, 1'b0, rvl, rd, rr, rl, 1'b1, 1'b0, eAra, cke_v, cke_v & rvl, eRadr, 1'b0);
  endfunction

  // END cycle.
  function automatic vec_t vEnd(input logic eErr, input logic [31:0] eAra);
    return mk(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, eAra, 1'b0, 1'b0, 2'd0, eErr);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    cke            = v.cke;
    replace_valid  = v.rv;
    replace_addr   = v.ra;
    axi_bus.arready = v.ard;
    axi_bus.rvalid = v.rvl;
    axi_bus.rdata  = v.rd;
    axi_bus.rresp  = v.rr;
    axi_bus.rlast  = v.rl;
    axi_bus.rid    = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    driveInputs(v);
    @(negedge clk);
    checkOutput({tag, ".replace"}, 32'(replace), 32'(v.eRep));
    checkOutput({tag, ".arvalid"}, 32'(axi_bus.arvalid), 32'(v.eArv));
    checkOutput({tag, ".araddr"}, axi_bus.araddr, v.eAra);
    checkOutput({tag, ".rready"}, 32'(axi_bus.rready), 32'(v.eRdy));
    checkOutput({tag, ".read_valid"}, 32'(read_valid), 32'(v.eRv));
    checkOutput({tag, ".error"}, 32'(error), 32'(v.eErr));
    if (v.eRv) begin
      checkOutput({tag, ".read_addr"}, 32'(read_addr), 32'(v.eRadr));
      checkOutput({tag, ".read_rdata"}, read_rdata, v.rd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill 1 (addr 0x4): normal 4-beat burst.
    table_q.push_back(vIdle(1'b1, 28'h4, 32'h0));
    table_q.push_back(vAddr(1'b1, 32'h40));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hD000_0000, 2'b00, 1'b0, 2'd0, 32'h40));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hD000_0001, 2'b00, 1'b0, 2'd1, 32'h40));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hD000_0002, 2'b00, 1'b0, 2'd2, 32'h40));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hD000_0003, 2'b00, 1'b1, 2'd3, 32'h40));
    table_q.push_back(vEnd(1'b0, 32'h40));
    // Fill 2 (addr 0x8), requested right after END: SLVERR on beat 2.
    table_q.push_back(vIdle(1'b1, 28'h8, 32'h40));
    table_q.push_back(vAddr(1'b1, 32'h80));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hA1A1_0000, 2'b00, 1'b0, 2'd0, 32'h80));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hA1A1_0001, 2'b00, 1'b0, 2'd1, 32'h80));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hA1A1_0002, 2'b10, 1'b0, 2'd2, 32'h80));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hA1A1_0003, 2'b00, 1'b1, 2'd3, 32'h80));
    table_q.push_back(vEnd(1'b1, 32'h80));
    // Fill 3 (addr 0xC): early rlast on beat 1 ends the fill short.
    table_q.push_back(vIdle(1'b1, 28'hC, 32'h80));
    table_q.push_back(vAddr(1'b1, 32'hC0));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hB2B2_0000, 2'b00, 1'b0, 2'd0, 32'hC0));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hB2B2_0001, 2'b00, 1'b1, 2'd1, 32'hC0));
    table_q.push_back(vEnd(1'b1, 32'hC0));
    // Fill 4 (addr 0x10): normal fill after the faulty one, error flag cleared.
    table_q.push_back(vIdle(1'b1, 28'h10, 32'hC0));
    table_q.push_back(vAddr(1'b1, 32'h100));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hC3C3_0000, 2'b00, 1'b0, 2'd0, 32'h100));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hC3C3_0001, 2'b00, 1'b0, 2'd1, 32'h100));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hC3C3_0002, 2'b00, 1'b0, 2'd2, 32'h100));
    table_q.push_back(vBeat(1'b1, 1'b1, 32'hC3C3_0003, 2'b00, 1'b1, 2'd3, 32'h100));
    table_q.push_back(vEnd(1'b0, 32'h100));
    table_q.push_back(vIdle(1'b0, 28'h0, 32'h100));

    // Reset state.
    arst_n = 1'b0;
    driveInputs(vIdle(1'b0, 28'h0, 32'h0));
    #12;
    checkOutput("rst.replace", 32'(replace), 32'h0);
    checkOutput("rst.arvalid", 32'(axi_bus.arvalid), 32'h0);
    checkOutput("rst.rready", 32'(axi_bus.rready), 32'h0);
    checkOutput("rst.read_valid", 32'(read_valid), 32'h0);
    checkOutput("rst.error", 32'(error), 32'h0);
    checkOutput("rst.araddr", axi_bus.araddr, 32'h0);
    checkOutput("const.arlen", 32'(axi_bus.arlen), 32'd3);
    checkOutput("const.arsize", 32'(axi_bus.arsize), 32'd2);
    checkOutput("const.arburst", 32'(axi_bus.arburst), 32'd1);
    checkOutput("const.arid", 32'(axi_bus.arid), 32'd0);
    checkOutput("const.arcache", 32'(axi_bus.arcache), 32'h3);
    checkOutput("const.arlock_prot_qos",
                {19'h0, axi_bus.arlock, axi_bus.arprot, axi_bus.arqos, 4'h0}, 32'h0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    foreach (table_q[i]) applyStimulus(table_q[i], $sformatf("tbl%0d", i));

    // AR stalled 5 cycles, then rvalid gaps.
    applyStimulus(vIdle(1'b1, 28'h14, 32'h100), "ar_req");
    for (int i = 0; i < 5; i++) applyStimulus(vAddr(1'b0, 32'h140), $sformatf("ar_stall%0d", i));
    applyStimulus(vAddr(1'b1, 32'h140), "ar_acc");
    applyStimulus(vBeat(1'b1, 1'b1, 32'hE4E4_0000, 2'b00, 1'b0, 2'd0, 32'h140), "gap_b0");
    applyStimulus(vBeat(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 2'd1, 32'h140), "gap_i0");
    applyStimulus(vBeat(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 2'd1, 32'h140), "gap_i1");
    applyStimulus(vBeat(1'b1, 1'b1, 32'hE4E4_0001, 2'b00, 1'b0, 2'd1, 32'h140), "gap_b1");
    applyStimulus(vBeat(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 2'd2, 32'h140), "gap_i2");
    applyStimulus(vBeat(1'b1, 1'b1, 32'hE4E4_0002, 2'b00, 1'b0, 2'd2, 32'h140), "gap_b2");
    applyStimulus(vBeat(1'b1, 1'b1, 32'hE4E4_0003, 2'b00, 1'b1, 2'd3, 32'h140), "gap_b3");
    applyStimulus(vEnd(1'b0, 32'h140), "gap_end");
    applyStimulus(vIdle(1'b0, 28'h0, 32'h140), "gap_idle");

    // Reset asserted during beat 2.
    applyStimulus(vIdle(1'b1, 28'h20, 32'h140), "rs_req");
    applyStimulus(vAddr(1'b1, 32'h200), "rs_addr");
    applyStimulus(vBeat(1'b1, 1'b1, 32'hF5F5_0000, 2'b00, 1'b0, 2'd0, 32'h200), "rs_b0");
    applyStimulus(vBeat(1'b1, 1'b1, 32'hF5F5_0001, 2'b00, 1'b0, 2'd1, 32'h200), "rs_b1");
    driveInputs(vBeat(1'b1, 1'b1, 32'hF5F5_0002, 2'b00, 1'b0, 2'd2, 32'h200));
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("rs_mid.replace", 32'(replace), 32'h0);
    checkOutput("rs_mid.arvalid", 32'(axi_bus.arvalid), 32'h0);
    checkOutput("rs_mid.rready", 32'(axi_bus.rready), 32'h0);
    checkOutput("rs_mid.read_valid", 32'(read_valid), 32'h0);
    checkOutput("rs_mid.error", 32'(error), 32'h0);
    checkOutput("rs_mid.araddr", axi_bus.araddr, 32'h0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Fill after reset, with clock enable low for 3 cycles mid-DATA.
    applyStimulus(vIdle(1'b1, 28'h30, 32'h0), "ck_req");
    applyStimulus(vAddr(1'b1, 32'h300), "ck_addr");
    applyStimulus(vBeat(1'b1, 1'b1, 32'h6060_0000, 2'b00, 1'b0, 2'd0, 32'h300), "ck_b0");
    applyStimulus(vBeat(1'b1, 1'b1, 32'h6060_0001, 2'b00, 1'b0, 2'd1, 32'h300), "ck_b1");
    for (int i = 0; i < 3; i++)
      applyStimulus(vBeat(1'b0, 1'b1, 32'h6060_0002, 2'b00, 1'b0, 2'd2, 32'h300), $sformatf("ck_off%0d", i));
    applyStimulus(vBeat(1'b1, 1'b1, 32'h6060_0002, 2'b00, 1'b0, 2'd2, 32'h300), "ck_b2");
    applyStimulus(vBeat(1'b1, 1'b1, 32'h6060_0003, 2'b00, 1'b1, 2'd3, 32'h300), "ck_b3");
    applyStimulus(vEnd(1'b0, 32'h300), "ck_end");
    applyStimulus(vIdle(1'b0, 28'h0, 32'h300), "ck_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
